// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled asynchronous serial receiver (start + DATA_BITS + [parity] + stop).
// Optional even-parity support is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_clk,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state, state_n;
    logic                 rxd_m, rxd_s;
    logic [TW-1:0]        tcnt, tcnt_n;
    logic [BW-1:0]        bcnt, bcnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_out_n;
    logic                 dv_n, fe_n;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_n, pe_n;
`endif

    always_comb begin
        state_n    = state;
        tcnt_n     = tcnt;
        bcnt_n     = bcnt;
        shreg_n    = shreg;
        data_out_n = data_out;
        dv_n       = 1'b0;
        fe_n       = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n     = perr_q;
        pe_n       = 1'b0;
`endif
        if (rx_clk) begin
            case (state)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state_n = S_START;
                        tcnt_n  = '0;
                    end
                end
                S_START: begin
                    if (tcnt == T_MID) begin
                        tcnt_n  = '0;
                        bcnt_n  = '0;
                        state_n = rxd_s ? S_IDLE : S_DATA;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tcnt == T_END) begin
                        tcnt_n  = '0;
                        shreg_n = {rxd_s, shreg[DATA_BITS-1:1]};
                        if (bcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_n = S_PARITY;
`else
                            state_n = S_STOP;
`endif
                        end else begin
                            bcnt_n = bcnt + 1'b1;
                        end
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tcnt == T_END) begin
                        tcnt_n  = '0;
                        perr_n  = rxd_s ^ (^shreg);
                        state_n = S_STOP;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tcnt == T_END) begin
                        tcnt_n = '0;
                        if (rxd_s) begin
                            data_out_n = shreg;
                            dv_n       = 1'b1;
`ifdef UART_RX_PARITY_EN
                            pe_n       = perr_q;
`endif
                            state_n    = S_IDLE;
                        end else begin
                            fe_n    = 1'b1;
                            state_n = S_BREAK;
                        end
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rxd_s) begin
                        state_n = S_IDLE;
                        tcnt_n  = '0;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    tcnt_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            bcnt        <= '0;
            shreg       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            tcnt        <= tcnt_n;
            bcnt        <= bcnt_n;
            shreg       <= shreg_n;
            data_out    <= data_out_n;
            data_valid  <= dv_n;
            frame_error <= fe_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perr_q       <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            perr_q       <= perr_n;
            parity_error <= pe_n;
        end
    end
`else
    assign parity_error = 1'b0;
`endif

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_rx_core;

    localparam int DB       = 8;
    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_clk = 1'b0;
    logic          rxd = 1'b1;
    logic [DB-1:0] data_out;
    logic          data_valid, frame_error, parity_error, busy;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_core #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_clk       (rx_clk),
        .rxd          (rxd),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_error  (frame_error),
        .parity_error (parity_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            rx_clk = (div == TICK_DIV - 1);
            div = (div + 1) % TICK_DIV;
        end
    end

    // Event log sampled on the falling edge.
    logic [DB-1:0] got_q[$];
    bit            got_pe[$];
    int            dv_cycles = 0, fe_cycles = 0, pe_cycles = 0;
    int            dv_busy_overlap = 0, fe_not_busy = 0;

    always @(negedge clk) begin
        if (data_valid) begin
            got_q.push_back(data_out);
            got_pe.push_back(parity_error);
            dv_cycles++;
            if (busy) dv_busy_overlap++;
        end
        if (frame_error) begin
            fe_cycles++;
            if (!busy) fe_not_busy++;
        end
        if (parity_error) pe_cycles++;
    end

    task automatic send_bits(input logic b, input int periods);
        rxd = b;
        repeat (periods * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input bit par_ok, input int stop_low);
        send_bits(1'b0, 1);
        for (int i = 0; i < DB; i++) send_bits(d[i], 1);
`ifdef UART_RX_PARITY_EN
        send_bits(par_ok ? ^d : ~^d, 1);
`endif
        if (stop_low > 0) send_bits(1'b0, stop_low);
        send_bits(1'b1, 1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++;
        if ({data_out, data_valid, frame_error, parity_error, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h/%b%b%b%b required 0/0000",
                     data_out, data_valid, frame_error, parity_error, busy);
        end
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || dv_cycles !== 0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b dv=%0d required busy=0 dv=0", busy, dv_cycles);
        end
    endtask

    task automatic test_good_frame();
        int b_dv, b_fe;
        b_dv = dv_cycles; b_fe = fe_cycles;
        send_frame(8'hA5, 1'b1, 0);
        send_bits(1'b1, 1);
        n_tests++;
        if (dv_cycles - b_dv !== 1) begin
            n_fail++;
            $display("FAIL good_dv_count: got %0d required 1", dv_cycles - b_dv);
        end
        n_tests++;
        if (data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL good_data: got %0h required a5", data_out);
        end
        n_tests++;
        if (fe_cycles - b_fe !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL good_fe_busy: fe=%0d busy=%b required fe=0 busy=0", fe_cycles - b_fe, busy);
        end
    endtask

    task automatic test_glitch();
        logic [DB-1:0] prev;
        int b_dv, b_fe;
        prev = data_out; b_dv = dv_cycles; b_fe = fe_cycles;
        rxd = 1'b0;
        repeat (3 * TICK_DIV) @(negedge clk);
        rxd = 1'b1;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_high: got %b required 1", busy);
        end
        repeat (BIT_CLKS) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || dv_cycles - b_dv !== 0 || fe_cycles - b_fe !== 0) begin
            n_fail++;
            $display("FAIL glitch_quiet: busy=%b dv=%0d fe=%0d required 0/0/0",
                     busy, dv_cycles - b_dv, fe_cycles - b_fe);
        end
        n_tests++;
        if (data_out !== prev) begin
            n_fail++;
            $display("FAIL glitch_data: got %0h required %0h", data_out, prev);
        end
    endtask

    task automatic test_frame_error();
        logic [DB-1:0] prev;
        int b_dv, b_fe;
        prev = data_out; b_dv = dv_cycles; b_fe = fe_cycles;
        send_frame(8'h3C, 1'b1, 3);
        n_tests++;
        if (fe_cycles - b_fe !== 1 || dv_cycles - b_dv !== 0) begin
            n_fail++;
            $display("FAIL ferr_pulse: fe=%0d dv=%0d required fe=1 dv=0", fe_cycles - b_fe, dv_cycles - b_dv);
        end
        n_tests++;
        if (data_out !== prev) begin
            n_fail++;
            $display("FAIL ferr_data_hold: got %0h required %0h", data_out, prev);
        end
        b_dv = dv_cycles;
        send_frame(8'h42, 1'b1, 0);
        n_tests++;
        if (dv_cycles - b_dv !== 1 || data_out !== 8'h42) begin
            n_fail++;
            $display("FAIL ferr_recover: dv=%0d data=%0h required dv=1 data=42", dv_cycles - b_dv, data_out);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = got_q.size();
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        n_tests++;
        if (got_q.size() - base !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d required 2", got_q.size() - base);
        end else begin
            n_tests++;
            if (got_q[base] !== 8'h00 || got_q[base+1] !== 8'hFF) begin
                n_fail++;
                $display("FAIL b2b_data: got %0h,%0h required 0,ff", got_q[base], got_q[base+1]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [DB-1:0] d;
        int b_dv;
        d = 8'h81; b_dv = dv_cycles;
        send_bits(1'b0, 1);
        for (int i = 0; i < 4; i++) send_bits(d[i], 1);
        rxd = d[4];
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({data_out, data_valid, frame_error, parity_error, busy} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %0h/%b%b%b%b required 0/0000",
                     data_out, data_valid, frame_error, parity_error, busy);
        end
        rxd = 1'b1;
        reset_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        n_tests++;
        if (dv_cycles - b_dv !== 0 || busy !== 1'b0 || data_out !== '0) begin
            n_fail++;
            $display("FAIL midreset_quiet: dv=%0d busy=%b data=%0h required 0/0/0",
                     dv_cycles - b_dv, busy, data_out);
        end
        send_frame(8'h81, 1'b1, 0);
        n_tests++;
        if (dv_cycles - b_dv !== 1 || data_out !== 8'h81) begin
            n_fail++;
            $display("FAIL midreset_recover: dv=%0d data=%0h required dv=1 data=81", dv_cycles - b_dv, data_out);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int b_dv, b_pe;
        b_dv = dv_cycles; b_pe = pe_cycles;
        send_frame(8'h07, 1'b1, 0);
        n_tests++;
        if (dv_cycles - b_dv !== 1 || pe_cycles - b_pe !== 0) begin
            n_fail++;
            $display("FAIL parity_ok: dv=%0d pe=%0d required dv=1 pe=0", dv_cycles - b_dv, pe_cycles - b_pe);
        end
        b_dv = dv_cycles; b_pe = pe_cycles;
        send_frame(8'h07, 1'b0, 0);
        n_tests++;
        if (dv_cycles - b_dv !== 1 || pe_cycles - b_pe !== 1 || got_pe[got_pe.size()-1] !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_bad: dv=%0d pe=%0d required dv=1 pe=1 together", dv_cycles - b_dv, pe_cycles - b_pe);
        end
    endtask
`endif

    // Reference: every frame with a high stop bit yields its byte; a low stop yields one frame error.
    task automatic test_random();
        logic [DB-1:0] exp_q[$];
        bit            exp_pe[$];
        logic [DB-1:0] d;
        bit            bad, par_ok;
        int            gap, exp_fe, base, b_fe, n_got;
        base = got_q.size(); b_fe = fe_cycles; exp_fe = 0;
        for (int k = 0; k < 24; k++) begin
            d      = DB'($urandom);
            bad    = ($urandom_range(0, 4) == 0);
            par_ok = ($urandom_range(0, 3) != 0);
            gap    = $urandom_range(0, 2);
            if (bad) exp_fe++;
            else begin
                exp_q.push_back(d);
`ifdef UART_RX_PARITY_EN
                exp_pe.push_back(!par_ok);
`else
                exp_pe.push_back(1'b0);
`endif
            end
            send_frame(d, par_ok, bad ? 2 : 0);
            if (gap > 0) send_bits(1'b1, gap);
        end
        n_got = got_q.size() - base;
        n_tests++;
        if (n_got !== exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d required %0d", n_got, exp_q.size());
        end else begin
            for (int k = 0; k < n_got; k++) begin
                n_tests++;
                if (got_q[base+k] !== exp_q[k] || got_pe[base+k] !== exp_pe[k]) begin
                    n_fail++;
                    $display("FAIL rand_frame%0d: got %0h pe=%b required %0h pe=%b",
                             k, got_q[base+k], got_pe[base+k], exp_q[k], exp_pe[k]);
                end
            end
        end
        n_tests++;
        if (fe_cycles - b_fe !== exp_fe) begin
            n_fail++;
            $display("FAIL rand_ferr: got %0d required %0d", fe_cycles - b_fe, exp_fe);
        end
    endtask

    task automatic test_strobe_rules();
        n_tests++;
        if (dv_busy_overlap !== 0 || fe_not_busy !== 0) begin
            n_fail++;
            $display("FAIL strobe_busy: dv_with_busy=%0d fe_without_busy=%0d required 0/0",
                     dv_busy_overlap, fe_not_busy);
        end
`ifndef UART_RX_PARITY_EN
        n_tests++;
        if (pe_cycles !== 0) begin
            n_fail++;
            $display("FAIL parity_tied: got %0d pulses required 0", pe_cycles);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_strobe_rules();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
